// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//
// Interrupt source side of the core's INTERRUPT handshake. Edge-triggered
// requests from NUM_SRC peripherals are latched into PENDING. Whenever the
// controller is idle, the highest-priority enabled pending source is presented
// to the core on INTERRUPT/IRQ_CAUSE. The controller then follows the trap
// through entry (IRQ_ACK), mret (IRQ_DONE) and a RETIRE_CYC-cycle restore
// window. Only after that window may it raise the next request.
//
// Optional feature macro: IRQ_TIMER_EN
//   When defined, a free-running TIMER_W-bit timer (MTIME) and a compare input
//   (TIMER_CMP) are added. The timer acts as an extra, lowest-priority,
//   always-enabled source with cause NUM_SRC. Its pending bit is internal and
//   does not appear in PENDING.
//   When undefined, the timer ports and all timer logic are absent.
//
// Ports
//   CLK          in   clock, all logic on posedge
//   RSTN         in   synchronous reset, active low
//   SRC_IN       in   [NUM_SRC]  request lines, rising edge = request
//   ENABLE_MASK  in   [NUM_SRC]  1 = source may raise INTERRUPT
//   IRQ_ACK      in   1-cycle pulse, core accepted the trap
//   IRQ_DONE     in   1-cycle pulse, core decoded mret
//   INTERRUPT    out  registered request to the core
//   IRQ_CAUSE    out  [CAUSE_W]  id of requested/serviced source
//   IRQ_BUSY     out  1 in REQUEST, SERVICE and RETIRE
//   PENDING      out  [NUM_SRC]  latched requests not yet acknowledged
//   TIMER_CMP    in   [TIMER_W]  timer compare value (IRQ_TIMER_EN only)
//   MTIME        out  [TIMER_W]  free-running timer (IRQ_TIMER_EN only)
// ---------------------------------------------------------------------------
module irq_controller #(
  parameter int NUM_SRC    = 4,
  parameter int CAUSE_W    = 3,
  parameter int RETIRE_CYC = 3,
  parameter int TIMER_W    = 32
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [NUM_SRC-1:0] SRC_IN,
  input  logic [NUM_SRC-1:0] ENABLE_MASK,
  input  logic               IRQ_ACK,
  input  logic               IRQ_DONE,
  output logic               INTERRUPT,
  output logic [CAUSE_W-1:0] IRQ_CAUSE,
  output logic               IRQ_BUSY,
  output logic [NUM_SRC-1:0] PENDING
`ifdef IRQ_TIMER_EN
  ,
  input  logic [TIMER_W-1:0] TIMER_CMP,
  output logic [TIMER_W-1:0] MTIME
`endif
);

  // Elaboration-time guard against parameter sets the logic cannot represent:
  // the cause field must hold NUM_SRC (the timer id), and the retire counter
  // is 4 bits wide.
  if ((2 ** CAUSE_W) <= NUM_SRC || RETIRE_CYC < 1 || RETIRE_CYC > 15 ||
      TIMER_W < 1) begin : g_param_check
    $error("irq_controller: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RETIRE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 int_q, int_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic [3:0]           retire_q, retire_d;

  logic [NUM_SRC-1:0]   prev_src_q;
  logic [NUM_SRC-1:0]   pend_q, pend_d;
  logic [NUM_SRC-1:0]   src_edge;
  logic [NUM_SRC-1:0]   ack_clr;

  // Candidate vector: external sources in bits [NUM_SRC-1:0], timer in bit
  // NUM_SRC so the same priority scan naturally gives it lowest priority.
  logic [NUM_SRC:0]     cand;
  logic                 cand_any;
  logic [CAUSE_W-1:0]   sel;
  logic                 timer_req;
  logic                 ack_take;

  // An acknowledge only counts while a request is outstanding.
  assign ack_take = (state_q == ST_REQUEST) && IRQ_ACK;

  // Per-source edge detection and pending bookkeeping. The set term is OR-ed
  // after the clear so a fresh edge in the acknowledge cycle is never lost.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_edge[gi] = SRC_IN[gi] & ~prev_src_q[gi];
    assign ack_clr[gi]  = ack_take && (cause_q == CAUSE_W'(gi));
    assign pend_d[gi]   = src_edge[gi] | (pend_q[gi] & ~ack_clr[gi]);
  end

`ifdef IRQ_TIMER_EN
  logic [TIMER_W-1:0] mtime_q;
  logic               tpend_q;
  logic               tpend_d;
  logic               timer_hit;
  logic               timer_clr;

  // A compare value of zero disables the timer source.
  assign timer_hit = (mtime_q == TIMER_CMP) && (TIMER_CMP != '0);
  assign timer_clr = ack_take && (cause_q == CAUSE_W'(NUM_SRC));
  assign tpend_d   = timer_hit | (tpend_q & ~timer_clr);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      mtime_q <= '0;
      tpend_q <= 1'b0;
    end else begin
      mtime_q <= mtime_q + TIMER_W'(1);
      tpend_q <= tpend_d;
    end
  end

  assign timer_req = tpend_q;
  assign MTIME     = mtime_q;
`else
  assign timer_req = 1'b0;
`endif

  assign cand     = {timer_req, pend_q & ENABLE_MASK};
  assign cand_any = |cand;

  // Fixed priority: scan from the top down so the lowest set index is the
  // last assignment and therefore wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC; i >= 0; i--) begin
      if (cand[i]) begin
        sel = CAUSE_W'(i);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    cause_d  = cause_q;
    retire_d = retire_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_any) begin
          state_d = ST_REQUEST;
          int_d   = 1'b1;
          cause_d = sel;
        end
      end
      ST_REQUEST: begin
        // Cause stays frozen here regardless of mask changes or new edges.
        if (IRQ_ACK) begin
          state_d = ST_SERVICE;
          int_d   = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (IRQ_DONE) begin
          state_d  = ST_RETIRE;
          retire_d = 4'(RETIRE_CYC);
        end
      end
      ST_RETIRE: begin
        // RETIRE_CYC cycles spent here; the idle cycle that follows makes
        // the DONE-to-next-INTERRUPT gap RETIRE_CYC+1.
        if (retire_q <= 4'd1) begin
          state_d  = ST_IDLE;
          cause_d  = '0;
          retire_d = '0;
        end else begin
          retire_d = retire_q - 4'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        int_d    = 1'b0;
        cause_d  = '0;
        retire_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      int_q      <= 1'b0;
      cause_q    <= '0;
      retire_q   <= '0;
      pend_q     <= '0;
      // Lines already high through reset must not look like new edges.
      prev_src_q <= SRC_IN;
    end else begin
      state_q    <= state_d;
      int_q      <= int_d;
      cause_q    <= cause_d;
      retire_q   <= retire_d;
      pend_q     <= pend_d;
      prev_src_q <= SRC_IN;
    end
  end

  assign INTERRUPT = int_q;
  assign IRQ_CAUSE = cause_q;
  assign IRQ_BUSY  = (state_q != ST_IDLE);
  assign PENDING   = pend_q;

endmodule

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller
//
// A stimulus process drives directed sequences, then random ones. Each cycle
// it advances a behavioural model of the controller's rules and queues the
// outputs expected after the next clock edge. A separate monitor checks those
// queued expectations against the DUT on the falling edge. It also pops
// expected request causes whenever INTERRUPT rises.
// ---------------------------------------------------------------------------
module tb_irq_controller;
  localparam int NUM_SRC    = 4;
  localparam int CAUSE_W    = 3;
  localparam int RETIRE_CYC = 3;
  localparam int TIMER_W    = 32;

  // Model phases (trap life cycle)
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SERV = 2;
  localparam int P_RET  = 3;

  logic               CLK = 1'b0;
  logic               RSTN;
  logic [NUM_SRC-1:0] SRC_IN;
  logic [NUM_SRC-1:0] ENABLE_MASK;
  logic               IRQ_ACK;
  logic               IRQ_DONE;
  logic               INTERRUPT;
  logic [CAUSE_W-1:0] IRQ_CAUSE;
  logic               IRQ_BUSY;
  logic [NUM_SRC-1:0] PENDING;
`ifdef IRQ_TIMER_EN
  logic [TIMER_W-1:0] TIMER_CMP;
  logic [TIMER_W-1:0] MTIME;
`endif

  always #5 CLK = ~CLK;

  irq_controller #(
    .NUM_SRC   (NUM_SRC),
    .CAUSE_W   (CAUSE_W),
    .RETIRE_CYC(RETIRE_CYC),
    .TIMER_W   (TIMER_W)
  ) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .SRC_IN     (SRC_IN),
    .ENABLE_MASK(ENABLE_MASK),
    .IRQ_ACK    (IRQ_ACK),
    .IRQ_DONE   (IRQ_DONE),
    .INTERRUPT  (INTERRUPT),
    .IRQ_CAUSE  (IRQ_CAUSE),
    .IRQ_BUSY   (IRQ_BUSY),
    .PENDING    (PENDING)
`ifdef IRQ_TIMER_EN
    ,
    .TIMER_CMP  (TIMER_CMP),
    .MTIME      (MTIME)
`endif
  );

  typedef struct {
    int                 cyc;
    logic               intr;
    logic               busy;
    logic [CAUSE_W-1:0] cause;
    logic [NUM_SRC-1:0] pend;
    logic [TIMER_W-1:0] mtime;
  } exp_t;

  exp_t exp_q[$];
  int   req_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Behavioural model state
  int                 m_phase;
  int                 m_cause;
  int                 m_done_edge;
  logic [NUM_SRC-1:0] m_pend;
  logic [NUM_SRC-1:0] m_prev;
  logic               m_tpend;
  logic [TIMER_W-1:0] m_mtime;
  logic [TIMER_W-1:0] m_cmp;

  // Apply one cycle of inputs, advance the model to the state after the next
  // edge, queue that expectation, then wait for the edge.
  task automatic step(input logic rstn, input logic [NUM_SRC-1:0] src,
                      input logic [NUM_SRC-1:0] mask, input logic ack,
                      input logic done);
    exp_t               e;
    int                 t;
    int                 pick;
    int                 clr;
    logic               hit;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] cand;
    RSTN        = rstn;
    SRC_IN      = src;
    ENABLE_MASK = mask;
    IRQ_ACK     = ack;
    IRQ_DONE    = done;
`ifdef IRQ_TIMER_EN
    TIMER_CMP   = m_cmp;
`endif
    t = edge_cnt + 1;
    if (!rstn) begin
      m_phase = P_IDLE;
      m_cause = 0;
      m_pend  = '0;
      m_prev  = src;
      m_tpend = 1'b0;
      m_mtime = '0;
    end else begin
      edges = src & ~m_prev;
      cand  = m_pend & mask;
      pick  = -1;
      for (int i = NUM_SRC - 1; i >= 0; i--) if (cand[i]) pick = i;
      hit = 1'b0;
`ifdef IRQ_TIMER_EN
      if (pick < 0 && m_tpend) pick = NUM_SRC;
      hit = (m_mtime == m_cmp) && (m_cmp != 0);
`endif
      clr = -1;
      case (m_phase)
        P_IDLE: if (pick >= 0) begin
          m_phase = P_REQ;
          m_cause = pick;
          req_q.push_back(pick);
          $display("cycle %0d: request issued, cause=%0d", t, pick);
        end
        P_REQ: if (ack) begin
          clr     = m_cause;
          m_phase = P_SERV;
        end
        P_SERV: if (done) begin
          m_done_edge = t;
          m_phase     = P_RET;
        end
        default: if (t == m_done_edge + RETIRE_CYC) begin
          m_phase = P_IDLE;
          m_cause = 0;
        end
      endcase
      if (clr >= 0 && clr < NUM_SRC) m_pend[clr] = 1'b0;
      m_pend = m_pend | edges;
      if (clr == NUM_SRC) m_tpend = 1'b0;
      if (hit) m_tpend = 1'b1;
      m_mtime = m_mtime + 1;
      m_prev  = src;
    end
    e.cyc   = t;
    e.intr  = (m_phase == P_REQ);
    e.busy  = (m_phase != P_IDLE);
    e.cause = CAUSE_W'(m_cause);
    e.pend  = m_pend;
    e.mtime = m_mtime;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t               e;
    int                 c;
    logic [CAUSE_W-1:0] ce;
    logic               prev_int;
    prev_int = 1'b0;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
        e = exp_q.pop_front();
        checks++;
        if ({INTERRUPT, IRQ_BUSY, IRQ_CAUSE, PENDING} !==
            {e.intr, e.busy, e.cause, e.pend}) begin
          errors++;
          $display("FAIL outputs cycle %0d: got int=%b busy=%b cause=%0d pend=%b, expected int=%b busy=%b cause=%0d pend=%b",
                   e.cyc, INTERRUPT, IRQ_BUSY, IRQ_CAUSE, PENDING,
                   e.intr, e.busy, e.cause, e.pend);
        end
`ifdef IRQ_TIMER_EN
        checks++;
        if (MTIME !== e.mtime) begin
          errors++;
          $display("FAIL mtime cycle %0d: got %0d, expected %0d", e.cyc, MTIME, e.mtime);
        end
`endif
      end
      if (INTERRUPT === 1'b1 && prev_int !== 1'b1) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL request cycle %0d: got unexpected request cause=%0d, expected none",
                   edge_cnt, IRQ_CAUSE);
        end else begin
          c  = req_q.pop_front();
          ce = CAUSE_W'(c);
          if (IRQ_CAUSE !== ce) begin
            errors++;
            $display("FAIL request cause cycle %0d: got %0d, expected %0d",
                     edge_cnt, IRQ_CAUSE, ce);
          end
        end
      end
      prev_int = INTERRUPT;
    end
  end

  // Stimulus
  initial begin
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] mask;
    m_cmp       = TIMER_W'(20);
    m_done_edge = 0;

    // Lines held high through reset and afterwards: no requests.
    repeat (3) step(1'b0, 4'hF, 4'hF, 1'b0, 1'b0);
    repeat (10) step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);

    // Single source 2: latency, hold until ACK, clear, done, retire.
    repeat (2) step(1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    repeat (5) step(1'b1, 4'b0100, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 4'hF, 1'b1, 1'b0);
    repeat (3) step(1'b1, 4'b0100, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 4'hF, 1'b0, 1'b1);
    repeat (6) step(1'b1, 4'b0000, 4'hF, 1'b0, 1'b0);

    // Sources 1 and 3 together: cause 1 first, cause 3 after retire.
    step(1'b1, 4'b1010, 4'hF, 1'b0, 1'b0);
    repeat (3) step(1'b1, 4'b1010, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'b1010, 4'hF, 1'b1, 1'b0);
    repeat (2) step(1'b1, 4'b1010, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'b1010, 4'hF, 1'b0, 1'b1);
    repeat (8) step(1'b1, 4'b1010, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'hF, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 4'hF, 1'b0, 1'b1);
    repeat (6) step(1'b1, 4'b0000, 4'hF, 1'b0, 1'b0);

    // Masked source 2 stays pending, fires once enabled.
    repeat (5) step(1'b1, 4'b0100, 4'b1011, 1'b0, 1'b0);
    repeat (3) step(1'b1, 4'b0100, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 4'hF, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 4'hF, 1'b0, 1'b1);
    repeat (6) step(1'b1, 4'b0000, 4'hF, 1'b0, 1'b0);

    // Source 0 re-rises in its own ACK cycle: stays pending, re-requests.
    step(1'b1, 4'b0001, 4'hF, 1'b0, 1'b0);
    repeat (2) step(1'b1, 4'b0001, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 4'hF, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 4'hF, 1'b0, 1'b1);
    repeat (6) step(1'b1, 4'b0001, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 4'hF, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 4'hF, 1'b0, 1'b1);
    repeat (6) step(1'b1, 4'b0000, 4'hF, 1'b0, 1'b0);

    // Random traffic with spurious ACK/DONE and occasional resets.
    src  = '0;
    mask = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      src = src ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 31) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 599) == 0)
        step(1'b0, src, mask, 1'b0, 1'b0);
      else
        step(1'b1, src, mask, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    end

`ifdef IRQ_TIMER_EN
    // Zero compare value: timer never requests.
    m_cmp = '0;
    repeat (3) step(1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
    repeat (300) step(1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
`endif

    repeat (4) step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    checks++;
    if (req_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d requests and %0d cycles outstanding, expected 0 and 0",
               req_q.size(), exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
